// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// Ovf is present only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             Out_valid;
    logic             Out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
`ifdef PIPE_ADDER_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output In_valid, A, B, Cin, Sub, Out_ready,
        input  In_ready, Out_valid, Sum, Cout
`ifdef PIPE_ADDER_OVF_EN
        , input Ovf
`endif
    );

    modport slave (
        input  In_valid, A, B, Cin, Sub, Out_ready,
        output In_ready, Out_valid, Sum, Cout
`ifdef PIPE_ADDER_OVF_EN
        , output Ovf
`endif
    );
endinterface

// File: rtl/pipe_adder.sv
// Chunked ripple-pipelined adder/subtractor with valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    pipe_adder_if.slave bus
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_split
        $error("pipe_adder: WIDTH (%0d) must split evenly into STAGES (%0d)", WIDTH, STAGES);
    end
    if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
        $error("pipe_adder: WIDTH (%0d) out of range 4..64", WIDTH);
    end

    logic              advance;
    logic [STAGES:1]   vld_pipe_q;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign advance      = !vld_pipe_q[STAGES] || bus.Out_ready;
    assign bus.In_ready = advance;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            vld_pipe_q <= '0;
        end else if (advance) begin
            vld_pipe_q[1] <= bus.In_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe_q[k] <= vld_pipe_q[k-1];
        end
    end

    // Stage k adds chunk k; remaining operand chunks ride ahead, finished
    // sum chunks accumulate behind, so only live bits are registered.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int REM = WIDTH - k * CW;

        logic [REM-1:0]        a_in;
        logic [REM-1:0]        b_in;
        logic                  c_in;
        logic [CW:0]           add_w;
        logic [(k+1)*CW-1:0]   s_d;
        logic [(k+1)*CW-1:0]   s_q;
        logic                  c_q;

        assign add_w = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

        if (k == 0) begin : g_first
            assign a_in = bus.A;
            assign b_in = bus.B ^ {WIDTH{bus.Sub}};
            assign c_in = bus.Cin ^ bus.Sub;
            assign s_d  = add_w[CW-1:0];
        end else begin : g_next
            assign a_in = g_stg[k-1].g_ops.a_q;
            assign b_in = g_stg[k-1].g_ops.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign s_d  = {add_w[CW-1:0], g_stg[k-1].s_q};
        end

        always_ff @(posedge Clk or posedge Rst) begin
            if (Rst) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (advance) begin
                s_q <= s_d;
                c_q <= add_w[CW];
            end
        end

        if (k < STAGES - 1) begin : g_ops
            logic [REM-CW-1:0] a_q;
            logic [REM-CW-1:0] b_q;

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[REM-1:CW];
                    b_q <= b_in[REM-1:CW];
                end
            end
        end
    end

    assign bus.Out_valid = vld_pipe_q[STAGES];
    assign bus.Sum       = g_stg[STAGES-1].s_q;
    assign bus.Cout      = g_stg[STAGES-1].c_q;

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB's sum bit and its operands.
    assign ovf_d = g_stg[STAGES-1].add_w[CW-1] ^ g_stg[STAGES-1].a_in[CW-1]
                 ^ g_stg[STAGES-1].b_in[CW-1]  ^ g_stg[STAGES-1].add_w[CW];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)          ovf_q <= 1'b0;
        else if (advance) ovf_q <= ovf_d;
    end

    assign bus.Ovf = ovf_q;
`endif
endmodule
